click_fifo_sync: RTL and testbench

Clocked, parametrised successor to the single-stage click buffer. It accepts 2-phase (transition-signalled) bundled-data transfers on its input channel and stores them in a DEPTH-entry FIFO. It re-issues them in order as 2-phase transfers on its output channel, with data width, buffer depth and synchroniser length all configurable. It sits at the boundary between self-timed click pipelines and the clocked logic, with occupancy and full/empty status exported to that logic.

---
 rtl/click_fifo_sync.sv | 106 ++++++++++
 tb/tb_click_fifo_sync.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/click_fifo_sync.sv
// Clocked FIFO bridging 2-phase (transition-signalled) bundled-data channels.
// DEPTH words in memory plus one held in the out_data launch register.
module click_fifo_sync #(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SYNC   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_req,
    output logic                       in_ack,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_req,
    input  logic                       out_ack,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              req_s;
    logic              ack_s;
    logic              wr_en;
    logic              rd_en;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] mem [DEPTH];

    generate
        if (SYNC == 0) begin : g_nosync
            assign req_s = in_req;
            assign ack_s = out_ack;
        end else begin : g_sync
            logic [SYNC-1:0] req_chain;
            logic [SYNC-1:0] ack_chain;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    req_chain <= '0;
                    ack_chain <= '0;
                end else begin
                    req_chain[0] <= in_req;
                    ack_chain[0] <= out_ack;
                    for (int unsigned i = 1; i < SYNC; i++) begin
                        req_chain[i] <= req_chain[i-1];
                        ack_chain[i] <= ack_chain[i-1];
                    end
                end
            end

            assign req_s = req_chain[SYNC-1];
            assign ack_s = ack_chain[SYNC-1];
        end
    endgenerate

    // Events are level differences between the two phase bits of each channel.
    assign wr_en = (req_s != in_ack) && !full;
    assign rd_en = (out_req == ack_s) && !empty;

    always_comb begin
        count_next = count;
        unique case ({wr_en, rd_en})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // empty is registered, so a word written this edge launches on the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_ack   <= 1'b0;
            out_req  <= 1'b0;
            out_data <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                in_ack <= ~in_ack;
            end
            if (rd_en) begin
                out_data <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_W'(1);
                out_req  <= ~out_req;
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: tb/tb_click_fifo_sync.sv
// Directed bench for click_fifo_sync: SYNC=2 instance for protocol/order tests,
// SYNC=0 instance for the clocked zero-delay throughput test.
module tb_click_fifo_sync;

    logic       clk;
    logic       reset;

    logic [7:0] in_data_a, out_data_a;
    logic       in_req_a, in_ack_a, out_req_a, out_ack_a;
    logic [2:0] count_a;
    logic       full_a, empty_a;

    logic [7:0] in_data_b, out_data_b;
    logic       in_req_b, in_ack_b, out_req_b, out_ack_b;
    logic [2:0] count_b;
    logic       full_b, empty_b;

    int passed = 0;
    int total  = 0;

    click_fifo_sync #(.DATA_W(8), .DEPTH(4), .SYNC(2)) dut_a (
        .clk(clk), .reset(reset),
        .in_data(in_data_a), .in_req(in_req_a), .in_ack(in_ack_a),
        .out_data(out_data_a), .out_req(out_req_a), .out_ack(out_ack_a),
        .count(count_a), .full(full_a), .empty(empty_a)
    );

    click_fifo_sync #(.DATA_W(8), .DEPTH(4), .SYNC(0)) dut_b (
        .clk(clk), .reset(reset),
        .in_data(in_data_b), .in_req(in_req_b), .in_ack(in_ack_b),
        .out_data(out_data_b), .out_req(out_req_b), .out_ack(out_ack_b),
        .count(count_b), .full(full_b), .empty(empty_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [7:0] d, input string tag);
        int n;
        in_data_a = d;
        in_req_a  = ~in_req_a;
        n = 0;
        while (in_ack_a !== in_req_a && n < 100) begin
            tick;
            n++;
        end
        check(tag, in_ack_a, in_req_a);
    endtask

    task automatic take_a(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (out_req_a === out_ack_a && n < 100) begin
            tick;
            n++;
        end
        check({tag, "_launch"}, out_req_a != out_ack_a, 1);
        check(tag, out_data_a, exp);
        out_ack_a = out_req_a;
    endtask

    logic [7:0] sb[$];
    logic [7:0] qb[$];
    logic [7:0] rnd_d;
    logic [7:0] rnd_exp;
    logic [7:0] thr_exp;
    logic       ia0;
    logic       seen_ia, seen_or, prev_ia, prev_or;
    bit         cons_done;
    int         maxc, rcvd_a, sent_b, rcvd_b, mon_n, cons_n;
    int         ia_edges[$];
    int         or_edges[$];

    initial begin
        reset = 1'b1;
        in_data_a = '0; in_req_a = 1'b0; out_ack_a = 1'b0;
        in_data_b = '0; in_req_b = 1'b0; out_ack_b = 1'b0;
        repeat (3) tick;
        check("rst_in_ack",   in_ack_a,   0);
        check("rst_out_req",  out_req_a,  0);
        check("rst_out_data", out_data_a, 0);
        check("rst_count",    count_a,    0);
        check("rst_empty",    empty_a,    1);
        check("rst_full",     full_a,     0);
        reset = 1'b0;
        tick;

        // single word, SYNC=2: in_req changes after edge 0
        in_data_a = 8'hA5;
        in_req_a  = 1'b1;
        tick; tick;
        check("sw_e2_in_ack", in_ack_a, 0);
        tick;
        check("sw_e3_in_ack", in_ack_a, 1);
        check("sw_e3_count",  count_a,  1);
        check("sw_e3_out_req", out_req_a, 0);
        tick;
        check("sw_e4_out_req",  out_req_a,  1);
        check("sw_e4_out_data", out_data_a, 8'hA5);
        check("sw_e4_count",    count_a,    0);
        check("sw_e4_empty",    empty_a,    1);

        // mid-stream reset with A5 outstanding and three words in memory
        push_a(8'hB1, "mr_push1");
        push_a(8'hB2, "mr_push2");
        push_a(8'hB3, "mr_push3");
        tick;
        check("mr_pre_count",   count_a,   3);
        check("mr_pre_out_req", out_req_a, 1);
        #3;
        reset = 1'b1;
        in_req_a = 1'b0;
        out_ack_a = 1'b0;
        #1;
        check("mr_in_ack",   in_ack_a,   0);
        check("mr_out_req",  out_req_a,  0);
        check("mr_out_data", out_data_a, 0);
        check("mr_count",    count_a,    0);
        check("mr_empty",    empty_a,    1);
        tick;
        reset = 1'b0;
        repeat (6) tick;
        check("post_rst_in_ack",  in_ack_a,  0);
        check("post_rst_out_req", out_req_a, 0);
        check("post_rst_count",   count_a,   0);
        check("post_rst_empty",   empty_a,   1);

        // fill with out_ack held
        for (int i = 1; i <= 5; i++) push_a(8'(i), "bp_push");
        tick; tick;
        check("bp_out_data", out_data_a, 8'h01);
        check("bp_count",    count_a,    4);
        check("bp_full",     full_a,     1);
        check("bp_empty",    empty_a,    0);
        in_data_a = 8'h06;
        in_req_a  = ~in_req_a;
        ia0 = in_ack_a;
        repeat (6) tick;
        check("bp_6th_held", in_ack_a, ia0);
        out_ack_a = ~out_ack_a;
        tick; tick;
        check("bp_e2_out_data", out_data_a, 8'h01);
        check("bp_e2_count",    count_a,    4);
        tick;
        check("bp_e3_out_data", out_data_a, 8'h02);
        check("bp_e3_count",    count_a,    3);
        check("bp_e3_full",     full_a,     0);
        check("bp_e3_in_ack",   in_ack_a,   ia0);
        tick;
        check("bp_e4_in_ack", in_ack_a, in_req_a);
        check("bp_e4_count",  count_a,  4);
        check("bp_e4_full",   full_a,   1);
        take_a(8'h02, "drain2");
        take_a(8'h03, "drain3");
        take_a(8'h04, "drain4");
        take_a(8'h05, "drain5");
        take_a(8'h06, "drain6");
        repeat (6) tick;
        check("drain_empty", empty_a, 1);
        check("drain_count", count_a, 0);
        check("drain_idle",  out_req_a, out_ack_a);

        // simultaneous write and launch with count=2
        push_a(8'h11, "sim_push1");
        push_a(8'h22, "sim_push2");
        push_a(8'h33, "sim_push3");
        repeat (4) tick;
        check("sim_pre_count",    count_a,    2);
        check("sim_pre_out_data", out_data_a, 8'h11);
        ia0 = in_ack_a;
        in_data_a = 8'h44;
        in_req_a  = ~in_req_a;
        out_ack_a = out_req_a;
        tick; tick;
        check("sim_e2_count",  count_a,  2);
        check("sim_e2_in_ack", in_ack_a, ia0);
        tick;
        check("sim_e3_in_ack",   in_ack_a,   in_req_a);
        check("sim_e3_out_data", out_data_a, 8'h22);
        check("sim_e3_count",    count_a,    2);
        take_a(8'h22, "sim_take22");
        take_a(8'h33, "sim_take33");
        take_a(8'h44, "sim_take44");
        repeat (6) tick;
        check("sim_end_empty", empty_a, 1);

        // 40 random words with random delays on both sides
        maxc = 0; rcvd_a = 0; cons_done = 0; mon_n = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 5)) tick;
                    rnd_d = 8'($urandom);
                    sb.push_back(rnd_d);
                    push_a(rnd_d, "rnd_push");
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 5)) tick;
                    cons_n = 0;
                    while (out_req_a === out_ack_a && cons_n < 200) begin
                        tick;
                        cons_n++;
                    end
                    if (out_req_a === out_ack_a) begin
                        check("rnd_launch_timeout", 0, 1);
                        break;
                    end
                    rnd_exp = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
                    check("rnd_data", out_data_a, rnd_exp);
                    rcvd_a++;
                    out_ack_a = out_req_a;
                end
                cons_done = 1;
            end
            begin
                while (!cons_done && mon_n < 5000) begin
                    @(negedge clk);
                    if (int'(count_a) > maxc) maxc = int'(count_a);
                    mon_n++;
                end
            end
        join
        check("rnd_count_le4", maxc <= 4, 1);
        check("rnd_received",  rcvd_a, 40);

        // SYNC=0 throughput against a clocked environment reacting one edge later
        seen_ia = 1'b0; seen_or = 1'b0; prev_ia = 1'b0; prev_or = 1'b0;
        sent_b = 0; rcvd_b = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (in_ack_b !== prev_ia) begin
                ia_edges.push_back(c);
                prev_ia = in_ack_b;
            end
            if (out_req_b !== prev_or) begin
                or_edges.push_back(c);
                prev_or = out_req_b;
                thr_exp = (qb.size() > 0) ? qb.pop_front() : 8'hXX;
                check("thr_data", out_data_b, thr_exp);
                rcvd_b++;
            end
            if (seen_ia == in_req_b && sent_b < 12) begin
                in_data_b = 8'hC0 + 8'(sent_b);
                qb.push_back(in_data_b);
                in_req_b = ~in_req_b;
                sent_b++;
            end
            if (seen_or != out_ack_b) out_ack_b = seen_or;
            seen_ia = in_ack_b;
            seen_or = out_req_b;
        end
        check("thr_received", rcvd_b, 12);
        check("thr_ia_toggles", ia_edges.size(), 12);
        for (int i = 1; i < ia_edges.size(); i++)
            check("thr_ia_gap", ia_edges[i] - ia_edges[i-1], 2);
        for (int i = 1; i < or_edges.size(); i++)
            check("thr_or_gap", or_edges[i] - or_edges[i-1], 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
